ras_ctrl: RTL
=============

// Module: ras_ctrl
// PURPOSE
//  Return-address-stack controller sitting beside the fetch-stage pre-decoder.
//  Consumes its call/return flags: pushes PC+4 on a call, pops on a return and
//  supplies the predicted return target to fetch in the same cycle.
//  Keeps speculative and committed pointer copies; a pipeline flush restores
//  the committed view.
// PARAMETERS
//  DEPTH   8   stack entries; power of two, >=2
//  ADDR_W  32  return address width
// PORTS
//  clk_i          in   1               clock
//  rst_i          in   1               async reset, active-high
//  instr_vld_i    in   1               fetch slot valid; qualifies call_i/return_i
//  call_i         in   1               pre-decode call flag
//  return_i       in   1               pre-decode return flag
//  pc_i           in   ADDR_W          PC of the fetched instruction
//  flush_i        in   1               pipeline flush; restore committed state
//  commit_vld_i   in   1               a control-flow instruction retires
//  commit_call_i  in   1               retiring instr is a call
//  commit_ret_i   in   1               retiring instr is a return
//  ras_vld_o      out  1               prediction valid this cycle
//  ras_addr_o     out  ADDR_W          predicted return address
//  ras_empty_o    out  1               speculative count == 0
//  ras_full_o     out  1               speculative count == DEPTH
// BEHAVIOUR
//  State: stack[DEPTH] of ADDR_W; spec_ptr/commit_ptr (log2 DEPTH, wrap);
//   spec_cnt/commit_cnt (0..DEPTH). Top = stack[ptr-1 mod DEPTH].
//  Reset: ptrs=0, cnts=0; stack contents don't-care. Outputs: ras_vld_o=0,
//   ras_addr_o=0, ras_empty_o=1, ras_full_o=0.
//  Prediction combinational, 0-cycle latency:
//   ras_vld_o = instr_vld_i & return_i & (spec_cnt!=0) & ~flush_i;
//   ras_addr_o = top when ras_vld_o, else 0.
//  Speculative update at clk edge, only when instr_vld_i & ~flush_i:
//   call only   : stack[spec_ptr]<=pc_i+4 (mod 2^ADDR_W); ptr+1;
//                 cnt=min(cnt+1,DEPTH). Full: overwrite oldest, cnt stays DEPTH.
//   return only : cnt>0 -> ptr-1, cnt-1; cnt==0 -> no change (underflow ignored).
//   call+return : cnt>0 -> top overwritten with pc_i+4, ptr/cnt unchanged
//                 (prediction = old top); cnt==0 -> treat as call only.
//   neither     : no change.
//  Committed update on commit_vld_i (independent of fetch): same ptr/cnt rules
//   as above on commit_ptr/commit_cnt; no stack write.
//  Flush: spec_ptr<=next commit_ptr, spec_cnt<=next commit_cnt (includes any
//   commit in the same cycle); fetch-side call/return that cycle discarded.
//   Entries overwritten speculatively past commit are not repaired (accepted
//   mispredict source).
//  Empty/full flags are registered-state views of spec_cnt.
//  Async reset mid-operation: all pointers/counts cleared immediately;
//   ras_vld_o drops in the same cycle.
//  Invalid inputs (call/return with instr_vld_i=0, commit_* with
//   commit_vld_i=0) are ignored.
// TESTING
//  1 Reset, return_i=1 vld=1 -> ras_vld_o=0, ras_empty_o=1, state unchanged.
//  2 call pc=0x1000, call pc=0x2000, return -> ras_addr_o=0x2004 vld=1; next
//    return -> 0x1004; third return -> ras_vld_o=0, empty=1.
//  3 DEPTH+1 calls pc=0x100*k (k=1..9) -> full=1 after 8th; 8 returns yield
//    0x904..0x204; 9th return vld=0 (oldest 0x104 overwritten).
//  4 call 0x1000; call+return same cycle pc=0x3000 -> ras_addr_o=0x1004,
//    next return -> 0x3004, cnt back to 0.
//  5 calls 0x1000 and 0x2000, commit first call only, flush -> cnt=1; next
//    return predicts 0x1004.
//  6 flush_i=1 with call_i=1 and commit_call_i=1 same cycle -> spec state
//    equals new committed state (cnt=1), fetch call dropped, ras_vld_o=0.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return-address stack beside the fetch pre-decoder: same-cycle return prediction,
// speculative and committed pointer views, flush restores the committed view.

// Pointer/count step for one view of the stack: push, pop or both in one slot.
module ras_ptr_step #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [CNT_W-1:0] cnt,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] nxt_ptr,
    output logic [CNT_W-1:0] nxt_cnt
);
    logic nonempty;

    always_comb begin
        nonempty = (cnt != '0);
        nxt_ptr  = ptr;
        nxt_cnt  = cnt;
        if (push && pop && nonempty) begin
            // top is replaced in place; depth unchanged
            nxt_ptr = ptr;
            nxt_cnt = cnt;
        end else if (push) begin
            // a full stack wraps onto its oldest entry
            nxt_ptr = ptr + PTR_W'(1);
            nxt_cnt = (cnt == CNT_W'(DEPTH)) ? cnt : cnt + CNT_W'(1);
        end else if (pop && nonempty) begin
            nxt_ptr = ptr - PTR_W'(1);
            nxt_cnt = cnt - CNT_W'(1);
        end
    end
endmodule

module ras_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_vld_i,
    input  logic              call_i,
    input  logic              return_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    input  logic              commit_vld_i,
    input  logic              commit_call_i,
    input  logic              commit_ret_i,
    output logic              ras_vld_o,
    output logic [ADDR_W-1:0] ras_addr_o,
    output logic              ras_empty_o,
    output logic              ras_full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SPEC  = 0;
    localparam int CMT   = 1;

    logic [ADDR_W-1:0] stack [DEPTH];

    logic [PTR_W-1:0] spec_ptr, commit_ptr;
    logic [CNT_W-1:0] spec_cnt, commit_cnt;

    // view 0 = speculative (fetch side), view 1 = committed (retire side)
    logic [1:0][PTR_W-1:0] cur_ptr, nxt_ptr;
    logic [1:0][CNT_W-1:0] cur_cnt, nxt_cnt;
    logic [1:0]            push, pop;

    logic [PTR_W-1:0]  top_idx, wr_idx;
    logic              fetch_wr;
    logic [ADDR_W-1:0] ret_addr;

    assign cur_ptr[SPEC] = spec_ptr;
    assign cur_cnt[SPEC] = spec_cnt;
    assign cur_ptr[CMT]  = commit_ptr;
    assign cur_cnt[CMT]  = commit_cnt;

    assign push[SPEC] = instr_vld_i & call_i;
    assign pop[SPEC]  = instr_vld_i & return_i;
    assign push[CMT]  = commit_vld_i & commit_call_i;
    assign pop[CMT]   = commit_vld_i & commit_ret_i;

    for (genvar g = 0; g < 2; g++) begin : g_view
        ras_ptr_step #(
            .DEPTH (DEPTH),
            .PTR_W (PTR_W),
            .CNT_W (CNT_W)
        ) u_step (
            .ptr     (cur_ptr[g]),
            .cnt     (cur_cnt[g]),
            .push    (push[g]),
            .pop     (pop[g]),
            .nxt_ptr (nxt_ptr[g]),
            .nxt_cnt (nxt_cnt[g])
        );
    end

    // flush takes the committed view including any same-cycle retire
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_ptr   <= '0;
            spec_cnt   <= '0;
            commit_ptr <= '0;
            commit_cnt <= '0;
        end else begin
            commit_ptr <= nxt_ptr[CMT];
            commit_cnt <= nxt_cnt[CMT];
            if (flush_i) begin
                spec_ptr <= nxt_ptr[CMT];
                spec_cnt <= nxt_cnt[CMT];
            end else begin
                spec_ptr <= nxt_ptr[SPEC];
                spec_cnt <= nxt_cnt[SPEC];
            end
        end
    end

    assign top_idx  = spec_ptr - PTR_W'(1);
    assign fetch_wr = instr_vld_i & call_i & ~flush_i;
    assign ret_addr = pc_i + ADDR_W'(4);

    // call+return on a non-empty stack replaces the top instead of pushing
    assign wr_idx = (return_i && (spec_cnt != '0)) ? top_idx : spec_ptr;

    always_ff @(posedge clk_i) begin
        if (!rst_i && fetch_wr)
            stack[wr_idx] <= ret_addr;
    end

    assign ras_vld_o   = instr_vld_i & return_i & (spec_cnt != '0) & ~flush_i;
    assign ras_addr_o  = ras_vld_o ? stack[top_idx] : '0;
    assign ras_empty_o = (spec_cnt == '0);
    assign ras_full_o  = (spec_cnt == CNT_W'(DEPTH));
endmodule
